// File: rtl/event_packer.sv
// ---------------------------------------------------------------------------
// event_packer
//
// Latches a 16 x 64-bit sampler snapshot when the sampler raises event_ready,
// acknowledges it with a 4-phase event_saved handshake, and streams the event
// as a framed 32-bit packet:
//   HEADER {MARKER, evt_cnt[23:0]}, TSTAMP, 32 DATA words, [CHECKSUM]
//
// The sampler is released as soon as the snapshot is in the local buffer, so
// stream back-pressure only ever delays acquisition by at most one packet.
//
// Build option:
//   EVENT_PACKER_CHECKSUM_EN - when defined, a CHECKSUM word (XOR of the 34
//                              preceding words) is appended and carries
//                              m_tlast. When undefined, m_tlast is on the
//                              last DATA word.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   event_ready  sampler snapshot valid (held until event_saved is seen)
//   evento       sampler snapshot, N_CH words of 64 bits
//   event_saved  snapshot latched (held until event_ready falls)
//   m_tdata      stream data
//   m_tvalid     stream valid
//   m_tready     stream ready from the sink
//   m_tlast      last word of the packet
//   busy         packet in progress
// ---------------------------------------------------------------------------
module event_packer #(
    parameter int         N_CH   = 16,
    parameter logic [7:0] MARKER = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        event_ready,
    input  logic [63:0] evento [N_CH],
    output logic        event_saved,
    output logic [31:0] m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tlast,
    output logic        busy
);

    localparam int                N_BEATS   = 2 * N_CH;
    localparam int                BEAT_W    = $clog2(N_BEATS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N_BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_TSTAMP,
        S_DATA
`ifdef EVENT_PACKER_CHECKSUM_EN
        , S_CHECKSUM
`endif
    } state_t;

    state_t            state_reg,   state_next;
    logic [BEAT_W-1:0] beat_reg,    beat_next;
    logic [23:0]       evt_cnt_reg, evt_cnt_next;
    logic [31:0]       tdata_reg,   tdata_next;
    logic              tvalid_reg,  tvalid_next;
    logic              tlast_reg,   tlast_next;
    logic              saved_reg,   saved_next;
    logic              busy_reg,    busy_next;
`ifdef EVENT_PACKER_CHECKSUM_EN
    logic [31:0]       csum_reg,    csum_next;
`endif

    logic [31:0]       ts_cnt_reg;
    logic [31:0]       tstamp_reg;
    logic [63:0]       snap_reg [N_CH];

    logic                     capture;
    logic                     hs;
    logic [BEAT_W-1:0]        beat_inc;
    logic [N_BEATS-1:0][31:0] data_words;

    // A capture needs the previous handshake to be fully closed
    // (event_saved low) as well as an idle streamer.
    assign capture  = (state_reg == S_IDLE) && event_ready && !saved_reg;
    assign hs       = tvalid_reg && m_tready;
    assign beat_inc = beat_reg + BEAT_W'(1);

    // Word view of the snapshot: low half of each channel goes out first.
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_words
        assign data_words[2*gi]   = snap_reg[gi][31:0];
        assign data_words[2*gi+1] = snap_reg[gi][63:32];
    end

    // Next-state and next-output logic. Every output word is prepared one
    // transition ahead so that m_tdata/m_tlast come straight from registers
    // and simply hold while the sink stalls.
    always_comb begin
        state_next   = state_reg;
        beat_next    = beat_reg;
        evt_cnt_next = evt_cnt_reg;
        tdata_next   = tdata_reg;
        tvalid_next  = tvalid_reg;
        tlast_next   = tlast_reg;
        busy_next    = busy_reg;
`ifdef EVENT_PACKER_CHECKSUM_EN
        csum_next    = csum_reg;
`endif

        // event_saved drops on the first edge that sees event_ready low.
        saved_next = saved_reg;
        if (!event_ready) begin
            saved_next = 1'b0;
        end else if (capture) begin
            saved_next = 1'b1;
        end

        case (state_reg)
            S_IDLE: begin
                if (capture) begin
                    state_next  = S_HEADER;
                    tdata_next  = {MARKER, evt_cnt_reg};
                    tvalid_next = 1'b1;
                    tlast_next  = 1'b0;
                    busy_next   = 1'b1;
`ifdef EVENT_PACKER_CHECKSUM_EN
                    csum_next   = {MARKER, evt_cnt_reg};
`endif
                end
            end

            S_HEADER: begin
                if (hs) begin
                    state_next   = S_TSTAMP;
                    evt_cnt_next = evt_cnt_reg + 24'd1;
                    tdata_next   = tstamp_reg;
`ifdef EVENT_PACKER_CHECKSUM_EN
                    csum_next    = csum_reg ^ tstamp_reg;
`endif
                end
            end

            S_TSTAMP: begin
                if (hs) begin
                    state_next = S_DATA;
                    beat_next  = '0;
                    tdata_next = data_words[0];
`ifdef EVENT_PACKER_CHECKSUM_EN
                    csum_next  = csum_reg ^ data_words[0];
`endif
                end
            end

            S_DATA: begin
                if (hs) begin
                    if (beat_reg == LAST_BEAT) begin
`ifdef EVENT_PACKER_CHECKSUM_EN
                        // csum_reg already holds the XOR of all 34 words.
                        state_next = S_CHECKSUM;
                        tdata_next = csum_reg;
                        tlast_next = 1'b1;
`else
                        state_next  = S_IDLE;
                        tvalid_next = 1'b0;
                        tlast_next  = 1'b0;
                        busy_next   = 1'b0;
`endif
                    end else begin
                        beat_next  = beat_inc;
                        tdata_next = data_words[beat_inc];
`ifdef EVENT_PACKER_CHECKSUM_EN
                        csum_next  = csum_reg ^ data_words[beat_inc];
`else
                        tlast_next = (beat_inc == LAST_BEAT);
`endif
                    end
                end
            end

`ifdef EVENT_PACKER_CHECKSUM_EN
            S_CHECKSUM: begin
                if (hs) begin
                    state_next  = S_IDLE;
                    tvalid_next = 1'b0;
                    tlast_next  = 1'b0;
                    busy_next   = 1'b0;
                end
            end
`endif

            default: begin
                state_next  = S_IDLE;
                tvalid_next = 1'b0;
                tlast_next  = 1'b0;
                busy_next   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            beat_reg    <= '0;
            evt_cnt_reg <= '0;
            tdata_reg   <= '0;
            tvalid_reg  <= 1'b0;
            tlast_reg   <= 1'b0;
            saved_reg   <= 1'b0;
            busy_reg    <= 1'b0;
`ifdef EVENT_PACKER_CHECKSUM_EN
            csum_reg    <= '0;
`endif
            ts_cnt_reg  <= '0;
            tstamp_reg  <= '0;
            for (int i = 0; i < N_CH; i++) begin
                snap_reg[i] <= '0;
            end
        end else begin
            state_reg   <= state_next;
            beat_reg    <= beat_next;
            evt_cnt_reg <= evt_cnt_next;
            tdata_reg   <= tdata_next;
            tvalid_reg  <= tvalid_next;
            tlast_reg   <= tlast_next;
            saved_reg   <= saved_next;
            busy_reg    <= busy_next;
`ifdef EVENT_PACKER_CHECKSUM_EN
            csum_reg    <= csum_next;
`endif
            // Free-running cycle counter; the capture edge records its
            // pre-increment value as the event timestamp.
            ts_cnt_reg  <= ts_cnt_reg + 32'd1;
            if (capture) begin
                tstamp_reg <= ts_cnt_reg;
                for (int i = 0; i < N_CH; i++) begin
                    snap_reg[i] <= evento[i];
                end
            end
        end
    end

    assign event_saved = saved_reg;
    assign m_tdata     = tdata_reg;
    assign m_tvalid    = tvalid_reg;
    assign m_tlast     = tlast_reg;
    assign busy        = busy_reg;

endmodule
